// File: rtl/dcache_responder.sv
// Direct-mapped write-back, write-allocate data cache with LL/SC link tracking
// and a halt-triggered flush of every dirty block to memory.
module dcache_responder #(
    parameter int NSETS    = 16,
    parameter int BLKWORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        datomic,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic [31:0] state_atomic,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int IW = $clog2(NSETS);
    localparam int TW = 32 - 3 - IW;
    localparam logic [IW-1:0] PTR_LAST = IW'(NSETS - 1);

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH_CHK, FLUSH0, FLUSH1, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            link_valid_q;
    logic [29:0]     link_addr_q;
    logic [NSETS-1:0] valid_q, dirty_q;
    logic [TW-1:0]   tag_q  [NSETS];
    logic [31:0]     data_q [NSETS][BLKWORDS];

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic          req_word;
    logic          hit, is_sc, link_match;
    logic          store_we, fill_we, fill_word, fill_done, clean_we;
    logic          link_set, link_clr;
    logic          unused_byte;

    assign req_tag     = dmemaddr[31:3+IW];
    assign req_idx     = dmemaddr[2+IW:3];
    assign req_word    = dmemaddr[2];
    assign unused_byte = ^dmemaddr[1:0];
    assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign is_sc       = dmemWEN && datomic;
    assign link_match  = link_valid_q && (link_addr_q == dmemaddr[31:2]);
    assign flushed     = (state_q == DONE);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        dhit         = 1'b0;
        dmemload     = 32'd0;
        state_atomic = 32'd2;
        dREN         = 1'b0;
        dWEN         = 1'b0;
        daddr        = 32'd0;
        dstore       = 32'd0;
        store_we     = 1'b0;
        fill_we      = 1'b0;
        fill_word    = 1'b0;
        fill_done    = 1'b0;
        clean_we     = 1'b0;
        link_set     = 1'b0;
        link_clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH_CHK;
                    ptr_d   = '0;
                end else if (dmemREN ^ dmemWEN) begin
                    // A failing SC completes at once without touching the cache or memory.
                    if (is_sc && !link_match) begin
                        dhit         = 1'b1;
                        state_atomic = 32'd0;
                        link_clr     = 1'b1;
                    end else if (hit) begin
                        dhit = 1'b1;
                        if (dmemREN) begin
                            dmemload = data_q[req_idx][req_word];
                            link_set = datomic;
                        end else begin
                            store_we = 1'b1;
                            if (is_sc) begin
                                state_atomic = 32'd1;
                                link_clr     = 1'b1;
                            end else begin
                                link_clr = link_match;
                            end
                        end
                    end else begin
                        state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WB0 : FETCH0;
                    end
                end
            end
            WB0, WB1: begin
                dWEN   = 1'b1;
                daddr  = {tag_q[req_idx], req_idx, (state_q == WB1), 2'b00};
                dstore = data_q[req_idx][state_q == WB1];
                if (!dwait) state_d = (state_q == WB0) ? WB1 : FETCH0;
            end
            FETCH0, FETCH1: begin
                dREN  = 1'b1;
                daddr = {req_tag, req_idx, (state_q == FETCH1), 2'b00};
                if (!dwait) begin
                    fill_we   = 1'b1;
                    fill_word = (state_q == FETCH1);
                    fill_done = (state_q == FETCH1);
                    state_d   = (state_q == FETCH0) ? FETCH1 : IDLE;
                end
            end
            FLUSH_CHK: begin
                if (valid_q[ptr_q] && dirty_q[ptr_q]) state_d = FLUSH0;
                else if (ptr_q == PTR_LAST)          state_d = DONE;
                else                                 ptr_d   = ptr_q + 1'b1;
            end
            FLUSH0, FLUSH1: begin
                dWEN   = 1'b1;
                daddr  = {tag_q[ptr_q], ptr_q, (state_q == FLUSH1), 2'b00};
                dstore = data_q[ptr_q][state_q == FLUSH1];
                if (!dwait) begin
                    if (state_q == FLUSH0) begin
                        state_d = FLUSH1;
                    end else begin
                        clean_we = 1'b1;
                        if (ptr_q == PTR_LAST) begin
                            state_d = DONE;
                        end else begin
                            ptr_d   = ptr_q + 1'b1;
                            state_d = FLUSH_CHK;
                        end
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (link_set) begin
                link_valid_q <= 1'b1;
                link_addr_q  <= dmemaddr[31:2];
            end else if (link_clr) begin
                link_valid_q <= 1'b0;
            end
        end
    end

    // Tag/data arrays; the fill overwrites the line in place and only marks it valid on the last word.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NSETS; i++) begin
                tag_q[i] <= '0;
                for (int w = 0; w < BLKWORDS; w++) data_q[i][w] <= '0;
            end
        end else begin
            if (store_we) begin
                data_q[req_idx][req_word] <= dmemstore;
                dirty_q[req_idx]          <= 1'b1;
            end
            if (fill_we) data_q[req_idx][fill_word] <= dload;
            if (fill_done) begin
                valid_q[req_idx] <= 1'b1;
                tag_q[req_idx]   <= req_tag;
                dirty_q[req_idx] <= 1'b0;
            end
            if (clean_we) dirty_q[ptr_q] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: a word memory model answers the cache
// and every directed step is checked against hand-worked expected values.
module tb_dcache_responder;
    logic        CLK, nRST;
    logic        dmemREN, dmemWEN, datomic, halt;
    logic [31:0] dmemaddr, dmemstore;
    logic        dhit, flushed, dREN, dWEN, dwait;
    logic [31:0] dmemload, state_atomic, daddr, dstore, dload;

    logic [31:0] mem [0:1023];
    logic [31:0] rdLog [0:63];
    logic [31:0] wrLog [0:63];
    logic [31:0] wrData [0:63];
    int rdCount, wrCount;
    int assertCount, failCount;

    dcache_responder #(.NSETS(16), .BLKWORDS(2)) dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .datomic(datomic), .halt(halt),
        .dhit(dhit), .dmemload(dmemload), .state_atomic(state_atomic), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign dload = mem[daddr[11:2]];

    // Memory model: logs every completed transfer and commits writes.
    always @(posedge CLK) begin
        if (nRST && !dwait) begin
            if (dREN && rdCount < 64) begin
                rdLog[rdCount] = daddr;
                rdCount++;
            end
            if (dWEN && wrCount < 64) begin
                wrLog[wrCount]  = daddr;
                wrData[wrCount] = dstore;
                wrCount++;
                mem[daddr[11:2]] <= dstore;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ren, input logic wen, input logic atom,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 output logic hitSeen, output logic [31:0] load,
                                 output logic [31:0] sa, output int cyc);
        @(negedge CLK);
        dmemREN = ren; dmemWEN = wen; datomic = atom;
        dmemaddr = addr; dmemstore = data;
        cyc = 0;
        #1;
        while (!dhit && cyc < 50) begin
            @(negedge CLK); #1;
            cyc++;
        end
        hitSeen = dhit; load = dmemload; sa = state_atomic;
        @(negedge CLK);
        dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    endtask

    logic        h;
    logic [31:0] ld, sa;
    int          cyc, rd0, wr0, n;

    initial begin
        assertCount = 0; failCount = 0; rdCount = 0; wrCount = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[16] = 32'hAAAA; mem[17] = 32'hBBBB;
        mem[80] = 32'hCCCC; mem[81] = 32'hDDDD;
        mem[194] = 32'h5555; mem[195] = 32'h6666;
        nRST = 1'b0; dmemREN = 0; dmemWEN = 0; datomic = 0; halt = 0;
        dmemaddr = 0; dmemstore = 0; dwait = 0;
        repeat (3) @(negedge CLK);
        #1;
        checkOutput("rst_dhit", {31'd0, dhit}, 32'd0);
        checkOutput("rst_dmemload", dmemload, 32'd0);
        checkOutput("rst_dREN", {31'd0, dREN}, 32'd0);
        checkOutput("rst_dWEN", {31'd0, dWEN}, 32'd0);
        checkOutput("rst_daddr", daddr, 32'd0);
        checkOutput("rst_dstore", dstore, 32'd0);
        checkOutput("rst_flushed", {31'd0, flushed}, 32'd0);
        checkOutput("rst_state_atomic", state_atomic, 32'd2);
        @(negedge CLK); nRST = 1'b1;

        // Cold load fills set 8 from 0x40/0x44.
        applyStimulus(1, 0, 0, 32'h40, 0, h, ld, sa, cyc);
        checkOutput("cold_hit", {31'd0, h}, 32'd1);
        checkOutput("cold_data", ld, 32'hAAAA);
        checkOutput("cold_cycles", cyc, 32'd3);
        checkOutput("cold_rdcount", rdCount, 32'd2);
        checkOutput("cold_rd0", rdLog[0], 32'h40);
        checkOutput("cold_rd1", rdLog[1], 32'h44);
        checkOutput("cold_sa", sa, 32'd2);
        applyStimulus(1, 0, 0, 32'h44, 0, h, ld, sa, cyc);
        checkOutput("rehit_data", ld, 32'hBBBB);
        checkOutput("rehit_cycles", cyc, 32'd0);
        checkOutput("rehit_rdcount", rdCount, 32'd2);

        // Dirty victim is written back before the conflicting fill.
        applyStimulus(0, 1, 0, 32'h40, 32'h1234, h, ld, sa, cyc);
        checkOutput("st_cycles", cyc, 32'd0);
        checkOutput("st_sa", sa, 32'd2);
        applyStimulus(1, 0, 0, 32'h140, 0, h, ld, sa, cyc);
        checkOutput("evict_cycles", cyc, 32'd5);
        checkOutput("evict_data", ld, 32'hCCCC);
        checkOutput("evict_wrcount", wrCount, 32'd2);
        checkOutput("evict_wr0", wrLog[0], 32'h40);
        checkOutput("evict_wd0", wrData[0], 32'h1234);
        checkOutput("evict_wr1", wrLog[1], 32'h44);
        checkOutput("evict_wd1", wrData[1], 32'hBBBB);
        checkOutput("evict_rd2", rdLog[2], 32'h140);
        checkOutput("evict_rd3", rdLog[3], 32'h144);

        // LL/SC.
        applyStimulus(1, 0, 1, 32'h80, 0, h, ld, sa, cyc);
        checkOutput("ll_cycles", cyc, 32'd3);
        checkOutput("ll_data", ld, 32'd0);
        applyStimulus(0, 1, 1, 32'h80, 32'd5, h, ld, sa, cyc);
        checkOutput("sc_ok_sa", sa, 32'd1);
        checkOutput("sc_ok_cycles", cyc, 32'd0);
        applyStimulus(1, 0, 0, 32'h80, 0, h, ld, sa, cyc);
        checkOutput("sc_ok_load", ld, 32'd5);
        checkOutput("load_sa", sa, 32'd2);
        applyStimulus(0, 1, 1, 32'h80, 32'd6, h, ld, sa, cyc);
        checkOutput("sc_nolink_sa", sa, 32'd0);
        checkOutput("sc_nolink_hit", {31'd0, h}, 32'd1);
        checkOutput("sc_nolink_cycles", cyc, 32'd0);
        applyStimulus(1, 0, 0, 32'h80, 0, h, ld, sa, cyc);
        checkOutput("sc_nolink_load", ld, 32'd5);
        applyStimulus(1, 0, 1, 32'h80, 0, h, ld, sa, cyc);
        applyStimulus(0, 1, 0, 32'h80, 32'd7, h, ld, sa, cyc);
        applyStimulus(0, 1, 1, 32'h80, 32'd9, h, ld, sa, cyc);
        checkOutput("sc_broken_sa", sa, 32'd0);
        applyStimulus(1, 0, 0, 32'h80, 0, h, ld, sa, cyc);
        checkOutput("sc_broken_load", ld, 32'd7);
        applyStimulus(1, 0, 1, 32'h80, 0, h, ld, sa, cyc);
        applyStimulus(1, 0, 0, 32'h84, 0, h, ld, sa, cyc);
        applyStimulus(0, 1, 1, 32'h80, 32'd11, h, ld, sa, cyc);
        checkOutput("sc_after_load_sa", sa, 32'd1);
        applyStimulus(1, 0, 0, 32'h80, 0, h, ld, sa, cyc);
        checkOutput("sc_after_load_data", ld, 32'd11);
        checkOutput("ll_sc_no_wb", wrCount, 32'd2);

        // Memory stall in the middle of a fill.
        rd0 = rdCount;
        @(negedge CLK);
        dwait = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h308;
        #1;
        checkOutput("stall_idle_dREN", {31'd0, dREN}, 32'd0);
        checkOutput("stall_idle_dhit", {31'd0, dhit}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); #1;
            checkOutput("stall_dREN", {31'd0, dREN}, 32'd1);
            checkOutput("stall_daddr", daddr, 32'h308);
            checkOutput("stall_dWEN", {31'd0, dWEN}, 32'd0);
            checkOutput("stall_rdcount", rdCount, rd0);
        end
        @(negedge CLK);
        dwait = 1'b0;
        n = 0;
        #1;
        while (!dhit && n < 20) begin
            @(negedge CLK); #1;
            n++;
        end
        checkOutput("stall_hit", {31'd0, dhit}, 32'd1);
        checkOutput("stall_data", dmemload, 32'h5555);
        checkOutput("stall_rdcount_after", rdCount, rd0 + 2);
        checkOutput("stall_rd0", rdLog[rd0], 32'h308);
        checkOutput("stall_rd1", rdLog[rd0+1], 32'h30C);
        @(negedge CLK);
        dmemREN = 1'b0;

        // Dirty sets 0 and 5, then halt and flush.
        applyStimulus(0, 1, 0, 32'h28, 32'h77, h, ld, sa, cyc);
        checkOutput("set5_cycles", cyc, 32'd3);
        wr0 = wrCount;
        @(negedge CLK);
        halt = 1'b1;
        n = 0;
        #1;
        while (!flushed && n < 200) begin
            @(negedge CLK); #1;
            n++;
        end
        checkOutput("flush_done", {31'd0, flushed}, 32'd1);
        checkOutput("flush_wrcount", wrCount - wr0, 32'd4);
        checkOutput("flush_wr0", wrLog[wr0],   32'h80);
        checkOutput("flush_wd0", wrData[wr0],  32'd11);
        checkOutput("flush_wr1", wrLog[wr0+1], 32'h84);
        checkOutput("flush_wd1", wrData[wr0+1], 32'd0);
        checkOutput("flush_wr2", wrLog[wr0+2], 32'h28);
        checkOutput("flush_wd2", wrData[wr0+2], 32'h77);
        checkOutput("flush_wr3", wrLog[wr0+3], 32'h2C);
        checkOutput("flush_mem80", mem[32], 32'd11);
        dmemREN = 1'b1; dmemaddr = 32'h40;
        repeat (5) @(negedge CLK);
        #1;
        checkOutput("flush_sticky", {31'd0, flushed}, 32'd1);
        checkOutput("flush_ignores_req", {31'd0, dhit}, 32'd0);
        checkOutput("flush_no_extra", wrCount - wr0, 32'd4);
        dmemREN = 1'b0; halt = 1'b0;

        // Reset in the middle of a flush write.
        @(negedge CLK); nRST = 1'b0;
        @(negedge CLK); nRST = 1'b1;
        applyStimulus(0, 1, 0, 32'h28, 32'h99, h, ld, sa, cyc);
        wr0 = wrCount;
        @(negedge CLK);
        dwait = 1'b1; halt = 1'b1;
        n = 0;
        #1;
        while (!dWEN && n < 50) begin
            @(negedge CLK); #1;
            n++;
        end
        checkOutput("midflush_dWEN", {31'd0, dWEN}, 32'd1);
        checkOutput("midflush_daddr", daddr, 32'h28);
        checkOutput("midflush_dstore", dstore, 32'h99);
        #1 nRST = 1'b0;
        #1;
        checkOutput("abort_dWEN", {31'd0, dWEN}, 32'd0);
        checkOutput("abort_daddr", daddr, 32'd0);
        checkOutput("abort_dstore", dstore, 32'd0);
        checkOutput("abort_flushed", {31'd0, flushed}, 32'd0);
        checkOutput("abort_sa", state_atomic, 32'd2);
        checkOutput("abort_no_write", wrCount, wr0);
        halt = 1'b0; dwait = 1'b0;
        @(negedge CLK); nRST = 1'b1;
        @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits between the pipelined datapath's data port (the responder side of datapath_cache_if) and the memory controller.
- Answers dmemREN/dmemWEN with dhit/dmemload.
- Implements LL/SC through a link register and reports SC outcome on state_atomic.
- Flushes all dirty blocks to memory when the datapath halts.

Parameters:
- NSETS, 16, number of sets (power of 2); index width IW = log2(NSETS).
- BLKWORDS, 2, words per block (fixed at 2; block offset is addr[2]).

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- dmemREN  in  1  datapath load request
- dmemWEN  in  1  datapath store request
- dmemaddr  in  32  byte address, word-aligned
- dmemstore  in  32  store data
- datomic  in  1  with REN = LL, with WEN = SC
- halt  in  1  datapath halted; start flush
- dhit  out  1  request complete this cycle
- dmemload  out  32  load data, valid when dhit
- state_atomic  out  32  SC result: 1 success, 0 fail, 32'd2 = no SC this cycle
- flushed  out  1  flush complete, sticky
- dREN  out  1  memory read request
- dWEN  out  1  memory write request
- daddr  out  32  memory word address
- dstore  out  32  memory write data
- dload  in  32  memory read data
- dwait  in  1  memory busy; a transfer completes on a cycle with dwait=0

Behaviour:
- Address split: tag = addr[31:3+IW], index = addr[2+IW:3], word = addr[2], byte = addr[1:0] (ignored).
- Reset: all valid and dirty bits 0; link_valid 0; state IDLE; flush pointer 0.
- Reset outputs: dhit=0, dmemload=0, dREN=0, dWEN=0, daddr=0, dstore=0, flushed=0, state_atomic=32'd2.
- Reset mid-operation aborts any memory transfer immediately.
- States: IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH_CHK, FLUSH0, FLUSH1, DONE.
- IDLE hit (valid and tag match, REN xor WEN):
  - dhit=1 combinationally in the same cycle.
  - Load: dmemload = word.
  - Store: word written and dirty set at the clock edge.
- IDLE miss: go to WB0 if the victim is valid and dirty, else FETCH0. dhit stays 0 until the request re-hits in IDLE after the fill.
- WB0/WB1:
  - dWEN=1, daddr = {victim tag, index, word 0/1, 2'b00}, dstore = that word.
  - Advance when dwait=0; WB1 goes to FETCH0.
- FETCH0/FETCH1:
  - dREN=1, daddr = {req tag, index, word 0/1, 00}.
  - On dwait=0, capture dload into the word.
  - FETCH1 sets valid, tag, dirty=0, then returns to IDLE.
- Only one of dREN/dWEN is high at a time. daddr, dstore and the request bits are held stable while dwait=1.
- LL (REN & datomic): on the hit cycle, link_addr <= dmemaddr and link_valid <= 1. A miss links only when the load completes.
- SC (WEN & datomic):
  - If link_valid and link_addr == dmemaddr: treated as a normal store (may miss/fill); state_atomic=1 on its dhit cycle.
  - Otherwise: dhit=1 immediately in IDLE, no write, no memory traffic, state_atomic=0.
  - Every SC clears link_valid on its dhit cycle.
- A non-atomic store hit whose word address equals link_addr clears link_valid. A load never clears it.
- state_atomic=32'd2 on every cycle that is not an SC dhit cycle.
- Halt:
  - Sampled in IDLE with no pending miss; enter FLUSH_CHK with pointer 0. Requests are ignored (dhit=0) from then on.
  - FLUSH_CHK: if set[ptr] is valid and dirty, go to FLUSH0, else increment ptr.
  - FLUSH0/FLUSH1 write both words as in WB, clear dirty, increment ptr, return to FLUSH_CHK.
  - When ptr wraps past NSETS-1, go to DONE: flushed=1 until reset.
- If halt rises mid-miss, the miss completes first, then flushing starts.

Test Plan:
- Load 0x40 cold → dREN at 0x40 then 0x44; dload 0xAAAA, 0xBBBB → dhit, dmemload=0xAAAA. Re-load 0x44 → dhit same cycle, data 0xBBBB, no dREN.
- Store 0x1234 to 0x40 (hit) → dirty. Load 0x140 (same index) → dWEN 0x40=0x1234, 0x44=0xBBBB, then fetch 0x140/0x144.
- LL 0x80 then SC 0x80 data 5 → state_atomic=1, later load returns 5. Repeat SC without LL → state_atomic=0, memory value stays 5.
- LL 0x80, plain store 7 to 0x80, SC 9 to 0x80 → state_atomic=0, load returns 7. Hold dwait=1 for 3 cycles mid-fill → outputs stable, no extra transfers.
- Dirty sets 0 and 5, assert halt → exactly 4 dWEN transfers in set order, then flushed=1 and held. Assert nRST=0 mid-flush → all outputs reset in the same cycle.
